// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Front end of the 4x4 keypad path. Drives the columns one-cold
//   (active-low) in rotation, synchronizes the raw row lines with two
//   flops, debounces both press and release, and presents one stable
//   key event to the number-bank stage, which captures a digit on the
//   rising edge of key_press.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-low reset
//   rows_in    raw asynchronous keypad rows, active-low, pulled up; bit0 = top row
//   cols       column drive, one-cold active-low; bit0 = leftmost column
//   R_val      synchronized row pattern of the last accepted key (one-cold)
//   C          column pattern of the last accepted key (one-cold)
//   key_press  high while a debounced key is held
//
// Parameters
//   SCAN_TICKS      clk cycles each column is driven while scanning (>= 4)
//   DEBOUNCE_TICKS  consecutive stable cycles to accept a press/release (>= 2)

module keypad_scanner #(
  parameter int unsigned SCAN_TICKS     = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_in,
  output logic [3:0] cols,
  output logic [3:0] R_val,
  output logic [3:0] C,
  output logic       key_press
);

  localparam int unsigned DW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned BW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_TICKS - 1);
  localparam logic [3:0]    COL_FIRST  = 4'b1110;

  typedef enum logic [1:0] {
    SCAN,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } state_t;

  state_t        state_q;
  logic [3:0]    sync1_q;
  logic [3:0]    rows_sync_q;
  logic [DW-1:0] dwell_q;
  logic [BW-1:0] db_q;
  logic [3:0]    cols_q;
  logic [3:0]    cand_row_q;
  logic [3:0]    cand_col_q;
  logic [3:0]    r_val_q;
  logic [3:0]    c_q;
  logic          key_press_q;

  logic [3:0]    rows_act;
  logic          rows_one_cold;
  logic          rows_match;
  logic          rows_idle;
  logic          dwell_done;
  logic          db_done;
  logic [3:0]    cols_next_d;

  // Active-high view of the synchronized rows; exactly one set bit means
  // exactly one key in the driven column.
  assign rows_act      = ~rows_sync_q;
  assign rows_one_cold = (rows_act != '0) && ((rows_act & (rows_act - 4'd1)) == '0);
  assign rows_match    = (rows_sync_q == cand_row_q);
  assign rows_idle     = (rows_sync_q == '1);
  assign dwell_done    = (dwell_q == DWELL_LAST);
  assign db_done       = (db_q == DB_LAST);

  // Rotate left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  assign cols_next_d   = {cols_q[2:0], cols_q[3]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= '1;
      rows_sync_q <= '1;
      state_q     <= SCAN;
      dwell_q     <= '0;
      db_q        <= '0;
      cols_q      <= COL_FIRST;
      cand_row_q  <= '1;
      cand_col_q  <= '1;
      r_val_q     <= '1;
      c_q         <= '1;
      key_press_q <= 1'b0;
    end else begin
      sync1_q     <= rows_in;
      rows_sync_q <= sync1_q;

      case (state_q)
        SCAN: begin
          // Rows are only judged at the end of the dwell so the new column
          // drive has had time to propagate through the synchronizer.
          if (dwell_done) begin
            dwell_q <= '0;
            if (rows_one_cold) begin
              cand_row_q <= rows_sync_q;
              cand_col_q <= cols_q;
              db_q       <= '0;
              state_q    <= DB_PRESS;
            end else begin
              cols_q <= cols_next_d;
            end
          end else begin
            dwell_q <= dwell_q + DW'(1);
          end
        end

        DB_PRESS: begin
          if (rows_match) begin
            if (db_done) begin
              db_q        <= '0;
              r_val_q     <= cand_row_q;
              c_q         <= cand_col_q;
              key_press_q <= 1'b1;
              state_q     <= HELD;
            end else begin
              db_q <= db_q + BW'(1);
            end
          end else begin
            db_q    <= '0;
            dwell_q <= '0;
            cols_q  <= cols_next_d;
            state_q <= SCAN;
          end
        end

        HELD: begin
          if (!rows_match) begin
            db_q    <= '0;
            state_q <= DB_RELEASE;
          end
        end

        DB_RELEASE: begin
          if (rows_idle) begin
            if (db_done) begin
              db_q        <= '0;
              dwell_q     <= '0;
              key_press_q <= 1'b0;
              cols_q      <= cols_next_d;
              state_q     <= SCAN;
            end else begin
              db_q <= db_q + BW'(1);
            end
          end else if (rows_match) begin
            // The key came back: treat the gap as release bounce.
            db_q    <= '0;
            state_q <= HELD;
          end else begin
            db_q <= '0;
          end
        end

        default: begin
          state_q <= SCAN;
        end
      endcase
    end
  end

  assign cols      = cols_q;
  assign R_val     = r_val_q;
  assign C         = c_q;
  assign key_press = key_press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int ST = 4;
  localparam int DT = 8;

  // Reference model phases (bench-local numbering).
  localparam int P_SCAN  = 0;
  localparam int P_PRESS = 1;
  localparam int P_HELD  = 2;
  localparam int P_REL   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows_in;
  logic [3:0] cols;
  logic [3:0] R_val;
  logic [3:0] C;
  logic       key_press;

  keypad_scanner #(
    .SCAN_TICKS     (ST),
    .DEBOUNCE_TICKS (DT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows_in   (rows_in),
    .cols      (cols),
    .R_val     (R_val),
    .C         (C),
    .key_press (key_press)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Physical keypad: bit r*4+c set means key at row r, column c is down.
  logic [15:0] key_mask = '0;

  // Behavioural reference model state.
  int         m_idx, m_phase, m_dwell, m_db;
  logic [3:0] m_s1, m_s2, m_cand_row, m_cand_col, m_R, m_C;
  logic       m_kp;

  function automatic logic [3:0] col_pat(input int idx);
    logic [3:0] one;
    one = 4'b0001 << idx;
    return ~one;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_phase = P_SCAN; m_dwell = 0; m_db = 0;
    m_s1 = 4'hF; m_s2 = 4'hF;
    m_cand_row = 4'hF; m_cand_col = 4'hF;
    m_R = 4'hF; m_C = 4'hF; m_kp = 1'b0;
  endtask

  // One clock edge of the reference, from the pre-edge inputs.
  task automatic model_step();
    logic [3:0] rs;
    if (!reset) begin
      model_reset();
    end else begin
      rs = m_s2;
      case (m_phase)
        P_SCAN: begin
          if (m_dwell == ST - 1) begin
            m_dwell = 0;
            if ($countones(~rs) == 1) begin
              m_cand_row = rs;
              m_cand_col = col_pat(m_idx);
              m_db = 0;
              m_phase = P_PRESS;
            end else begin
              m_idx = (m_idx + 1) % 4;
            end
          end else begin
            m_dwell++;
          end
        end
        P_PRESS: begin
          if (rs == m_cand_row) begin
            if (m_db == DT - 1) begin
              m_phase = P_HELD; m_db = 0;
              m_R = m_cand_row; m_C = m_cand_col; m_kp = 1'b1;
            end else begin
              m_db++;
            end
          end else begin
            m_phase = P_SCAN; m_db = 0; m_dwell = 0;
            m_idx = (m_idx + 1) % 4;
          end
        end
        P_HELD: begin
          if (rs != m_cand_row) begin
            m_db = 0; m_phase = P_REL;
          end
        end
        default: begin
          if (rs == 4'hF) begin
            if (m_db == DT - 1) begin
              m_phase = P_SCAN; m_kp = 1'b0; m_db = 0; m_dwell = 0;
              m_idx = (m_idx + 1) % 4;
            end else begin
              m_db++;
            end
          end else if (rs == m_cand_row) begin
            m_phase = P_HELD; m_db = 0;
          end else begin
            m_db = 0;
          end
        end
      endcase
      m_s2 = m_s1;
      m_s1 = rows_in;
    end
  endtask

  task automatic drive_rows();
    logic [3:0] r;
    r = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (key_mask[rr*4+cc] && cols[cc] === 1'b0) r[rr] = 1'b0;
    rows_in = r;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("cols", {4'h0, cols}, {4'h0, col_pat(m_idx)});
    chk("R_val", {4'h0, R_val}, {4'h0, m_R});
    chk("C", {4'h0, C}, {4'h0, m_C});
    chk("key_press", {7'h0, key_press}, {7'h0, m_kp});
    drive_rows();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press(input int r, input int c);
    key_mask[r*4+c] = 1'b1;
    drive_rows();
  endtask

  task automatic lift(input int r, input int c);
    key_mask[r*4+c] = 1'b0;
    drive_rows();
  endtask

  task automatic wait_kp(input string tag, input logic v, input int lim);
    int n;
    n = 0;
    while (key_press !== v && n < lim) begin
      cycle();
      n++;
    end
    chk(tag, {7'h0, key_press}, {7'h0, v});
  endtask

  task automatic wait_phase(input string tag, input int p, input int lim);
    int  n;
    logic ok;
    n = 0;
    while (m_phase != p && n < lim) begin
      cycle();
      n++;
    end
    ok = (m_phase == p);
    chk(tag, {7'h0, ok}, 8'h01);
  endtask

  logic [3:0] seq [5];
  int         det;
  int         r_sel;

  initial begin
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011;
    seq[3] = 4'b0111; seq[4] = 4'b1110;
    reset   = 1'b0;
    rows_in = 4'hF;
    model_reset();

    // 1. Reset and free-running rotation.
    run(3);
    chk("rst_cols", {4'h0, cols}, 8'h0E);
    chk("rst_R", {4'h0, R_val}, 8'h0F);
    chk("rst_C", {4'h0, C}, 8'h0F);
    chk("rst_kp", {7'h0, key_press}, 8'h00);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("rotate", {4'h0, cols}, {4'h0, seq[k]});
      run(ST);
    end

    // 2. Clean press of row 2 / column 1.
    press(2, 1);
    wait_phase("detect", P_PRESS, 40);
    det = cyc;
    wait_kp("press_rise", 1'b1, 40);
    chk("press_latency", 8'(cyc - det), 8'd8);
    chk("press_R", {4'h0, R_val}, 8'h0B);
    chk("press_C", {4'h0, C}, 8'h0D);
    chk("press_cols", {4'h0, cols}, 8'h0D);
    run(10);
    chk("held_R", {4'h0, R_val}, 8'h0B);

    // 4. Release bounce then real release.
    lift(2, 1);
    run(4);
    press(2, 1);
    run(12);
    chk("bounce_kp", {7'h0, key_press}, 8'h01);
    chk("bounce_cols", {4'h0, cols}, 8'h0D);
    lift(2, 1);
    wait_kp("release_fall", 1'b0, 40);
    chk("release_cols", {4'h0, cols}, 8'h0B);
    chk("release_R", {4'h0, R_val}, 8'h0B);
    chk("release_C", {4'h0, C}, 8'h0D);

    // 3. Press bounce: short press aborted inside debounce.
    press(2, 1);
    wait_phase("pb_detect", P_PRESS, 60);
    run(3);
    lift(2, 1);
    wait_phase("pb_abort", P_SCAN, 20);
    chk("pb_cols", {4'h0, cols}, 8'h0B);
    run(20);
    chk("pb_kp", {7'h0, key_press}, 8'h00);

    // 5. Two keys in one column, then a second key during HELD.
    press(2, 0);
    press(3, 0);
    run(24);
    chk("multi_kp", {7'h0, key_press}, 8'h00);
    lift(2, 0);
    lift(3, 0);
    press(2, 1);
    wait_kp("k1_rise", 1'b1, 60);
    press(0, 3);
    run(20);
    chk("k2_hidden_C", {4'h0, C}, 8'h0D);
    chk("k2_hidden_R", {4'h0, R_val}, 8'h0B);
    lift(2, 1);
    wait_kp("k1_fall", 1'b0, 40);
    wait_kp("k2_rise", 1'b1, 60);
    chk("k2_R", {4'h0, R_val}, 8'h0E);
    chk("k2_C", {4'h0, C}, 8'h07);
    lift(0, 3);
    wait_kp("k2_fall", 1'b0, 40);

    // 6. Reset mid-DB_PRESS and mid-HELD.
    press(2, 1);
    wait_phase("r6_detect", P_PRESS, 60);
    run(2);
    reset = 1'b0;
    run(1);
    chk("r6a_kp", {7'h0, key_press}, 8'h00);
    chk("r6a_cols", {4'h0, cols}, 8'h0E);
    chk("r6a_R", {4'h0, R_val}, 8'h0F);
    chk("r6a_C", {4'h0, C}, 8'h0F);
    lift(2, 1);
    run(2);
    reset = 1'b1;
    run(40);
    chk("r6a_quiet", {7'h0, key_press}, 8'h00);
    press(2, 1);
    wait_kp("r6b_rise", 1'b1, 60);
    run(3);
    reset = 1'b0;
    lift(2, 1);
    run(1);
    chk("r6b_kp", {7'h0, key_press}, 8'h00);
    chk("r6b_cols", {4'h0, cols}, 8'h0E);
    chk("r6b_R", {4'h0, R_val}, 8'h0F);
    chk("r6b_C", {4'h0, C}, 8'h0F);
    reset = 1'b1;
    run(40);
    chk("r6b_quiet", {7'h0, key_press}, 8'h00);

    // Randomized keypad activity against the reference model.
    for (int i = 0; i < 1500; i++) begin
      r_sel = $urandom_range(0, 99);
      if (r_sel < 3)      key_mask = '0;
      else if (r_sel < 6) key_mask = 16'h1 << $urandom_range(0, 15);
      else if (r_sel < 7) key_mask = key_mask | (16'h1 << $urandom_range(0, 15));
      reset = ($urandom_range(0, 399) != 0);
      drive_rows();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
